pp_csa_accumulator: RTL

//  Multi-cycle reduction stage directly downstream of the radix-4 Booth partial-product generator.

---
 rtl/pp_csa_accumulator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pp_csa_accumulator.sv
// pp_csa_accumulator
//   Multi-cycle reduction of the 13 radix-4 Booth partial-product rows of a
//   24x24 mantissa multiply. A row set is captured on a valid/ready
//   handshake, folded PARM_PP_PER_CYC rows per cycle into a carry-save
//   (sum, carry) pair, resolved with one carry-propagate add, and held on
//   the output until the downstream accepts it.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   row set on pp_NN_i is valid
//   in_ready_o   block can accept a new row set (high only in IDLE)
//   pp_00_i..pp_12_i  Booth rows, 2*PARM_MANT+3 bits each, pre-shifted
//   out_valid_o  product_o / err_o valid
//   out_ready_i  downstream accepts the product
//   product_o    unsigned mantissa product, 2*PARM_MANT+2 bits
//   err_o        top bit of the resolved row sum (malformed rows)
//
// The port list carries exactly 13 rows, so PARM_PP must stay at 13.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new row set
// ACCUM | folding K rows per cycle into the carry-save pair
// ADD   | resolving sum + carry into product / error flag
// DONE  | holding the result until out_ready_i

module pp_csa_accumulator #(
  parameter int PARM_MANT       = 23,
  parameter int PARM_PP         = 13,
  parameter int PARM_PP_PER_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*PARM_MANT+2:0] pp_00_i,
  input  logic [2*PARM_MANT+2:0] pp_01_i,
  input  logic [2*PARM_MANT+2:0] pp_02_i,
  input  logic [2*PARM_MANT+2:0] pp_03_i,
  input  logic [2*PARM_MANT+2:0] pp_04_i,
  input  logic [2*PARM_MANT+2:0] pp_05_i,
  input  logic [2*PARM_MANT+2:0] pp_06_i,
  input  logic [2*PARM_MANT+2:0] pp_07_i,
  input  logic [2*PARM_MANT+2:0] pp_08_i,
  input  logic [2*PARM_MANT+2:0] pp_09_i,
  input  logic [2*PARM_MANT+2:0] pp_10_i,
  input  logic [2*PARM_MANT+2:0] pp_11_i,
  input  logic [2*PARM_MANT+2:0] pp_12_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*PARM_MANT+1:0] product_o,
  output logic                   err_o
);

  localparam int PPW   = 2*PARM_MANT + 3;
  localparam int PRODW = 2*PARM_MANT + 2;
  localparam int NROWS = PARM_PP;
  localparam int K     = PARM_PP_PER_CYC;
  // Wide enough to hold the last index plus one full step without wrapping.
  localparam int IDX_W = $clog2(NROWS + K + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PPW-1:0]   pp_in   [NROWS];
  logic [PPW-1:0]   rows    [NROWS];
  logic [PPW-1:0]   sum_q;
  logic [PPW-1:0]   carry_q;
  logic [IDX_W-1:0] idx;

  logic [PPW-1:0]   sum_nx;
  logic [PPW-1:0]   carry_nx;
  logic [PPW-1:0]   carry_tmp;
  logic [PPW-1:0]   row_sel;
  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] idx_nx;
  logic             accum_last;
  logic [PPW-1:0]   resolved;

  assign pp_in[0]  = pp_00_i;
  assign pp_in[1]  = pp_01_i;
  assign pp_in[2]  = pp_02_i;
  assign pp_in[3]  = pp_03_i;
  assign pp_in[4]  = pp_04_i;
  assign pp_in[5]  = pp_05_i;
  assign pp_in[6]  = pp_06_i;
  assign pp_in[7]  = pp_07_i;
  assign pp_in[8]  = pp_08_i;
  assign pp_in[9]  = pp_09_i;
  assign pp_in[10] = pp_10_i;
  assign pp_in[11] = pp_11_i;
  assign pp_in[12] = pp_12_i;

  // Chain of K 3:2 compressors starting at row idx. Slots past the last row
  // are skipped so the final, partially filled cycle leaves the pair as is.
  always_comb begin
    sum_nx    = sum_q;
    carry_nx  = carry_q;
    carry_tmp = '0;
    row_sel   = '0;
    pos       = '0;
    for (int j = 0; j < K; j++) begin
      pos     = idx + IDX_W'(j);
      row_sel = '0;
      for (int r = 0; r < NROWS; r++) begin
        if (pos == IDX_W'(r)) row_sel = rows[r];
      end
      if (pos < IDX_W'(NROWS)) begin
        // Majority shifted left; the bit leaving the top is dropped (mod 2^PPW).
        carry_tmp = ((sum_nx & carry_nx) | (sum_nx & row_sel) | (carry_nx & row_sel)) << 1;
        sum_nx    = sum_nx ^ carry_nx ^ row_sel;
        carry_nx  = carry_tmp;
      end
    end
  end

  assign idx_nx     = idx + IDX_W'(K);
  assign accum_last = (idx_nx >= IDX_W'(NROWS));
  assign resolved   = sum_q + carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      product_o   <= '0;
      err_o       <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      idx         <= '0;
      for (int r = 0; r < NROWS; r++) rows[r] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            for (int r = 0; r < NROWS; r++) rows[r] <= pp_in[r];
            sum_q      <= '0;
            carry_q    <= '0;
            idx        <= '0;
            in_ready_o <= 1'b0;
            state      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          sum_q   <= sum_nx;
          carry_q <= carry_nx;
          idx     <= idx_nx;
          if (accum_last) state <= S_ADD;
        end
        S_ADD: begin
          product_o   <= resolved[PRODW-1:0];
          err_o       <= resolved[PPW-1];
          out_valid_o <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
